// File: rtl/sig_window_monitor.sv
// sig_window_monitor: debounces a raw level, emits edge pulses, and reports per-window edge/high-cycle statistics over valid/ready.
module sig_window_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int WIN_CYCLES = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sig_i,
  input  logic             clr_i,
  output logic             filt_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             rpt_valid_o,
  input  logic             rpt_ready_i,
  output logic [CNT_W-1:0] rpt_rise_o,
  output logic [CNT_W-1:0] rpt_high_o,
  output logic             overrun_o
);
  typedef enum logic [1:0] {LOW, RISE_PEND, HIGH, FALL_PEND} state_t;
  localparam logic [3:0] STAB = 4'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] WLAST = CNT_W'(WIN_CYCLES - 1);
  state_t st;
  logic [3:0] pc, pc_inc;
  logic [CNT_W-1:0] wc, hi_acc, ri_acc;
  logic wend;
  assign pc_inc = pc + 4'd1;
  assign wend = wc == WLAST;
  // Clear and disable both hold the filter; only the one-cycle pulses are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st <= LOW;
      pc <= '0;
      filt_o <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else if (clr_i || !en_i) begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      case (st)
        LOW: if (sig_i) begin
          if (STAB == 4'd1) begin
            st <= HIGH;
            filt_o <= 1'b1;
            rise_o <= 1'b1;
          end else begin
            st <= RISE_PEND;
            pc <= 4'd1;
          end
        end
        RISE_PEND: if (!sig_i) begin
          st <= LOW;
          pc <= '0;
        end else if (pc_inc == STAB) begin
          st <= HIGH;
          pc <= '0;
          filt_o <= 1'b1;
          rise_o <= 1'b1;
        end else pc <= pc_inc;
        HIGH: if (!sig_i) begin
          if (STAB == 4'd1) begin
            st <= LOW;
            filt_o <= 1'b0;
            fall_o <= 1'b1;
          end else begin
            st <= FALL_PEND;
            pc <= 4'd1;
          end
        end
        default: if (sig_i) begin
          st <= HIGH;
          pc <= '0;
        end else if (pc_inc == STAB) begin
          st <= LOW;
          pc <= '0;
          filt_o <= 1'b0;
          fall_o <= 1'b1;
        end else pc <= pc_inc;
      endcase
    end
  end
  // A pending report blocks a new one unless it transfers on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wc <= '0;
      hi_acc <= '0;
      ri_acc <= '0;
      rpt_valid_o <= 1'b0;
      rpt_rise_o <= '0;
      rpt_high_o <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (rpt_valid_o && rpt_ready_i) rpt_valid_o <= 1'b0;
      if (en_i) begin
        if (wend) begin
          wc <= '0;
          hi_acc <= '0;
          ri_acc <= '0;
          if (!rpt_valid_o || rpt_ready_i) begin
            rpt_valid_o <= 1'b1;
            rpt_high_o <= hi_acc + CNT_W'(filt_o);
            rpt_rise_o <= ri_acc + CNT_W'(rise_o);
          end else overrun_o <= 1'b1;
        end else begin
          wc <= wc + 1'b1;
          hi_acc <= hi_acc + CNT_W'(filt_o);
          ri_acc <= ri_acc + CNT_W'(rise_o);
        end
      end
    end
  end
endmodule

// File: tb/tb_sig_window_monitor.sv
// tb_sig_window_monitor: directed scenarios plus randomized traffic against a run-length/window-count reference model.
module tb_sig_window_monitor;
  localparam int STABLE = 4;
  localparam int WIN = 16;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, sig = 1'b0, clr = 1'b0, ready = 1'b0;
  logic filt, rise, fall, valid, ovr;
  logic [W-1:0] rr, rh;
  int checks = 0, failures = 0;
  logic m_filt, m_rise, m_fall, m_valid, m_ovr;
  int m_run, m_wc;
  logic [W-1:0] m_h, m_r, m_rr, m_rh;
  always #5 clk = ~clk;
  sig_window_monitor #(.STABLE_CYCLES(STABLE), .WIN_CYCLES(WIN), .CNT_W(W)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sig_i(sig), .clr_i(clr),
    .filt_o(filt), .rise_o(rise), .fall_o(fall), .rpt_valid_o(valid),
    .rpt_ready_i(ready), .rpt_rise_o(rr), .rpt_high_o(rh), .overrun_o(ovr)
  );
  task automatic model_reset();
    m_filt = 0; m_rise = 0; m_fall = 0; m_valid = 0; m_ovr = 0;
    m_run = 0; m_wc = 0; m_h = 0; m_r = 0; m_rr = 0; m_rh = 0;
  endtask
  // The model counts consecutive opposite-level samples and whole-window sums.
  task automatic tick(input logic e, input logic s, input logic c, input logic r);
    logic pf, pr, old_valid;
    en = e; sig = s; clr = c; ready = r;
    if (c) begin
      m_rise = 0; m_fall = 0; m_valid = 0; m_ovr = 0;
      m_wc = 0; m_h = 0; m_r = 0; m_rr = 0; m_rh = 0;
    end else begin
      pf = m_filt; pr = m_rise; old_valid = m_valid;
      m_rise = 0; m_fall = 0;
      if (e) begin
        if (s != m_filt) begin
          m_run++;
          if (m_run == STABLE) begin
            m_filt = s; m_run = 0; m_rise = s; m_fall = !s;
          end
        end else m_run = 0;
      end
      if (old_valid && r) m_valid = 0;
      if (e) begin
        m_h = m_h + W'(pf);
        m_r = m_r + W'(pr);
        m_wc++;
        if (m_wc == WIN) begin
          if (!old_valid || r) begin
            m_valid = 1; m_rr = m_r; m_rh = m_h;
          end else m_ovr = 1;
          m_wc = 0; m_h = 0; m_r = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sig = 1'b0; clr = 1'b0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sig = 1'b1; clr = 1'b0; ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({filt, rise, fall, valid, ovr, rr, rh} !== '0) begin
        failures++;
        $display("FAIL reset_during cyc=%0d got=%h want=0", i, {filt, rise, fall, valid, ovr, rr, rh});
      end
    end
    rst = 1'b0;
    model_reset();
    tick(1, 1, 0, 1);
    checks++;
    if ({filt, rise, fall, valid, ovr, rr, rh} !== '0) begin
      failures++;
      $display("FAIL reset_after got=%h want=0", {filt, rise, fall, valid, ovr, rr, rh});
    end
  endtask
  task automatic test_glitch();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, i < 3, 0, 1);
      checks++;
      if (filt !== 1'b0 || rise !== 1'b0) begin
        failures++;
        $display("FAIL glitch_hold e%0d filt=%b rise=%b want 0 0", i + 1, filt, rise);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 0, 1);
      checks++;
      if (filt !== (i == 3)) begin
        failures++;
        $display("FAIL glitch_restart e%0d filt=%b want=%b", i + 1, filt, i == 3);
      end
    end
  endtask
  task automatic test_clean_edge();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      tick(1, 1, 0, 1);
      checks++;
      if (filt !== (i >= 4) || rise !== (i == 4) || fall !== 1'b0) begin
        failures++;
        $display("FAIL clean_filter e%0d filt=%b rise=%b fall=%b want %b %b 0", i, filt, rise, fall, i >= 4, i == 4);
      end
      if (i >= 16) begin
        checks++;
        if (valid !== (i == 16) || (i == 16 && (rr !== 8'd1 || rh !== 8'd12))) begin
          failures++;
          $display("FAIL clean_report e%0d valid=%b rise=%0d high=%0d want valid=%b 1 12", i, valid, rr, rh, i == 16);
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      tick(1, 1, 0, 0);
      if (i == 16 || i == 31 || i == 32 || i == 40) begin
        checks++;
        if (valid !== 1'b1 || rr !== 8'd1 || rh !== 8'd12 || ovr !== (i >= 32)) begin
          failures++;
          $display("FAIL backpressure e%0d valid=%b rise=%0d high=%0d ovr=%b want 1 1 12 %b", i, valid, rr, rh, ovr, i >= 32);
        end
      end
    end
    tick(1, 1, 0, 1);
    checks++;
    if (valid !== 1'b0 || ovr !== 1'b1) begin
      failures++;
      $display("FAIL transfer valid=%b ovr=%b want 0 1", valid, ovr);
    end
  endtask
  task automatic test_enable_freeze();
    do_reset();
    tick(1, 1, 0, 1);
    tick(1, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1'($urandom_range(0, 1)), 0, 1);
      checks++;
      if (filt !== 1'b0 || rise !== 1'b0) begin
        failures++;
        $display("FAIL freeze c%0d filt=%b rise=%b want 0 0", i, filt, rise);
      end
    end
    tick(1, 1, 0, 1);
    checks++;
    if (filt !== 1'b0) begin
      failures++;
      $display("FAIL freeze_resume1 filt=%b want 0", filt);
    end
    tick(1, 1, 0, 1);
    checks++;
    if (filt !== 1'b1 || rise !== 1'b1) begin
      failures++;
      $display("FAIL freeze_resume2 filt=%b rise=%b want 1 1", filt, rise);
    end
  endtask
  task automatic test_clear();
    do_reset();
    repeat (39) tick(1, 1, 0, 0);
    checks++;
    if (ovr !== 1'b1 || filt !== 1'b1) begin
      failures++;
      $display("FAIL clear_setup ovr=%b filt=%b want 1 1", ovr, filt);
    end
    tick(1, 1, 1, 0);
    checks++;
    if (ovr !== 1'b0 || valid !== 1'b0 || filt !== 1'b1 || rise !== 1'b0 || rh !== 8'd0 || rr !== 8'd0) begin
      failures++;
      $display("FAIL clear ovr=%b valid=%b filt=%b rise=%b rr=%0d rh=%0d want 0 0 1 0 0 0", ovr, valid, filt, rise, rr, rh);
    end
    for (int i = 1; i <= 16; i++) begin
      tick(1, 1, 0, 1);
      if (i >= 15) begin
        checks++;
        if (valid !== (i == 16) || (i == 16 && (rh !== 8'd16 || rr !== 8'd0))) begin
          failures++;
          $display("FAIL clear_report e%0d valid=%b rise=%0d high=%0d want valid=%b 0 16", i, valid, rr, rh, i == 16);
        end
      end
    end
  endtask
  task automatic test_random();
    logic lvl = 1'b0;
    logic [2*W+4:0] got, want;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 22) lvl = ~lvl;
      tick($urandom_range(0, 99) < 80, lvl, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 40);
      got = {filt, rise, fall, valid, ovr, rr, rh};
      want = {m_filt, m_rise, m_fall, m_valid, m_ovr, m_rr, m_rh};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL random c%0d got=%h want=%h", i, got, want);
      end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_clean_edge();
    test_back_to_back();
    test_enable_freeze();
    test_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sig_window_monitor.md
# sig_window_monitor

Downstream consumer of the single-bit combinational result of the gate-logic block (its `E_o`). It debounces that signal with a persistence filter and emits one-cycle rise/fall pulses. It also accumulates per-window statistics (rising-edge count, high-cycle count) and hands each window's report out over a valid/ready interface, flagging any report lost to back-pressure.

## Interface
- `STABLE_CYCLES`, 4: consecutive enabled samples of the opposite level required before `filt_o` changes; legal range 1..15.
- `WIN_CYCLES`, 16: enabled cycles per statistics window; must satisfy 2 ≤ WIN_CYCLES < 2**CNT_W.
- `CNT_W`, 8: width of report counters.
- `clk_i`  in  1  sole clock, rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `en_i`  in  1  sample enable; when 0 the whole block holds state.
- `sig_i`  in  1  raw input (driven by upstream `E_o`).
- `clr_i`  in  1  synchronous clear of window/report/overrun state.
- `filt_o`  out  1  debounced level.
- `rise_o`  out  1  one-cycle pulse, first cycle `filt_o` is 1.
- `fall_o`  out  1  one-cycle pulse, first cycle `filt_o` is 0.
- `rpt_valid_o`  out  1  report available.
- `rpt_ready_i`  in  1  consumer accepts report.
- `rpt_rise_o`  out  CNT_W  rising edges in reported window.
- `rpt_high_o`  out  CNT_W  cycles `filt_o` was 1 in reported window.
- `overrun_o`  out  1  sticky: a window report was dropped.

## Operation
- Priority per edge: `rst_i` > `clr_i` > `en_i` activity.
- Reset: every output 0; filter state LOW; persistence counter, window counter, accumulators 0.
- Filter FSM: LOW, RISE_PEND, HIGH, FALL_PEND.
  - LOW: on enabled edge with `sig_i`=1 → RISE_PEND, persistence count=1 (if STABLE_CYCLES=1, go directly to HIGH).
  - RISE_PEND: `sig_i`=1 increments count; reaching STABLE_CYCLES → HIGH; `sig_i`=0 → LOW, count 0.
  - HIGH/FALL_PEND: mirror image with `sig_i`=0.
  - `filt_o`=1 in HIGH and FALL_PEND; `rise_o` asserts for exactly the cycle after entering HIGH, `fall_o` after entering LOW from FALL_PEND.
- Window: counter advances 0..WIN_CYCLES-1 on each enabled edge, wraps to 0.
  - Each enabled edge adds registered `filt_o` to high accumulator and registered `rise_o` to rise accumulator.
  - On the enabled edge where counter = WIN_CYCLES-1, the final values (including that edge's contribution) form the report; accumulators restart at 0.
- Report handshake:
  - Report loads into `rpt_*_o`; `rpt_valid_o` set.
  - Transfer occurs on an edge with `rpt_valid_o` & `rpt_ready_i`; `rpt_valid_o` drops unless a new report loads on that same edge (then stays 1 with new data).
  - While `rpt_valid_o` & !`rpt_ready_i`, data held stable.
  - Window end while report pending and not transferring: new report discarded, old retained, `overrun_o` set.
- `clr_i`: zeros window counter, accumulators, `rpt_valid_o`, `rpt_*_o`, `overrun_o`; filter state and `filt_o` unaffected; `rise_o`/`fall_o` forced 0 that cycle.
- `en_i`=0: filter, window, accumulators frozen; pulses deassert; handshake transfers still complete (`rpt_ready_i` honoured).

## Timing
- All outputs registered; no combinational input-to-output path.
- Filter latency: `sig_i` stable from enabled edge E1 → `filt_o` changes after edge E(STABLE_CYCLES).
- Report visible the cycle after the window-ending edge.
- Reset mid-window or mid-handshake: report and partial window lost; `overrun_o` cleared.

## Test plan
- Reset: assert `rst_i` 2 cycles with `sig_i`=1 → all outputs 0 during and immediately after.
- Glitch rejection: `en_i`=1, `sig_i`=1 for 3 edges then 0 → `filt_o`, `rise_o` stay 0; state returns LOW.
- Clean edge + first report: `sig_i`=1 from E1 onward, `rpt_ready_i`=1 → `filt_o`=1 after E4, `rise_o` one cycle after E4; after E16 `rpt_valid_o`=1 one cycle, `rpt_rise_o`=1, `rpt_high_o`=12.
- Back-pressure/overrun: same stimulus, `rpt_ready_i`=0 through E40 → report (1,12) held from after E16; after E32 `overrun_o`=1, data still (1,12); raise ready → single transfer, `overrun_o` remains 1.
- Enable freeze: drop `en_i` for 5 cycles mid-RISE_PEND at count 2 → no change; on re-enable, 2 more `sig_i`=1 edges set `filt_o`.
- Clear: `clr_i` pulse at window count 7 with `overrun_o`=1 and `filt_o`=1 → `overrun_o`, `rpt_valid_o` 0; `filt_o` stays 1; next report after 16 further enabled edges shows `rpt_high_o`=16, `rpt_rise_o`=0.
